// File: rtl/crc_control_pkg.sv
// rtl/crc_control_pkg.sv - shared encodings for the CRC sequencing controller
package crc_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BYTE0 = 3'd1,
        ST_BYTE1 = 3'd2,
        ST_BYTE2 = 3'd3,
        ST_BYTE3 = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] BYTE_0 = 2'd0;
    localparam logic [1:0] BYTE_1 = 2'd1;
    localparam logic [1:0] BYTE_2 = 2'd2;
    localparam logic [1:0] BYTE_3 = 2'd3;

endpackage

// File: rtl/crc_control.sv
// rtl/crc_control.sv - byte-stepping sequencer and bus stall logic for the CRC datapath
module crc_control
    import crc_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dr_wr,
    input  logic [1:0] dr_size,
    input  logic       dr_rd,
    input  logic       init_wr,
    input  logic       poly_wr,
    input  logic       cr_reset,
    input  logic [1:0] size_out,
    output logic       bus_wait,
    output logic       busy,
    output logic       buffer_en,
    output logic       byte_en,
    output logic [1:0] byte_sel,
    output logic       bypass_byte0,
    output logic       bypass_size,
    output logic       crc_out_en,
    output logic       set_crc_init_sel,
    output logic       clear_crc_init_sel,
    output logic       buffer_rst,
    output logic       crc_init_en,
    output logic       crc_poly_en
);

    state_t state, state_nxt;
    logic   buf_full, buf_full_nxt;
    logic   acc;
    state_t end_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
        end else begin
            state    <= state_nxt;
            buf_full <= buf_full_nxt;
        end
    end

    // dr_size is consumed by the datapath buffer; only the accept decision lives here
    always_comb begin
        busy         = (state != ST_IDLE) || buf_full;
        byte_en      = (state == ST_BYTE0);
        acc          = dr_wr && !cr_reset && (!buf_full || byte_en);
        buffer_en    = acc;
        buf_full_nxt = cr_reset ? 1'b0 : (acc || (buf_full && !byte_en));
        end_state    = buf_full_nxt ? ST_BYTE0 : ST_IDLE;

        crc_init_en        = init_wr && !busy && !cr_reset;
        crc_poly_en        = poly_wr && !busy;
        clear_crc_init_sel = cr_reset || crc_init_en;
        buffer_rst         = cr_reset;
        bus_wait           = (dr_wr && !acc) || ((init_wr || poly_wr || dr_rd) && busy)
                             || (init_wr && cr_reset);
    end

    always_comb begin
        state_nxt        = state;
        byte_sel         = BYTE_0;
        bypass_byte0     = 1'b0;
        bypass_size      = 1'b0;
        crc_out_en       = 1'b0;
        set_crc_init_sel = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Jump straight on the accept edge so BYTE0 follows the write by one cycle
                state_nxt = end_state;
            end
            ST_BYTE0: begin
                byte_sel         = BYTE_0;
                bypass_byte0     = 1'b1;
                bypass_size      = 1'b1;
                crc_out_en       = 1'b1;
                set_crc_init_sel = 1'b1;
                state_nxt        = (size_out == SIZE_BYTE) ? end_state : ST_BYTE1;
            end
            ST_BYTE1: begin
                byte_sel   = BYTE_1;
                crc_out_en = 1'b1;
                state_nxt  = (size_out == SIZE_HALF) ? end_state : ST_BYTE2;
            end
            ST_BYTE2: begin
                byte_sel   = BYTE_2;
                crc_out_en = 1'b1;
                state_nxt  = ST_BYTE3;
            end
            ST_BYTE3: begin
                byte_sel   = BYTE_3;
                crc_out_en = 1'b1;
                state_nxt  = end_state;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (cr_reset) state_nxt = ST_IDLE;
    end

endmodule

// File: tb/tb_crc_control.sv
// tb/tb_crc_control.sv - randomized and directed checks of crc_control against a byte-queue model
module tb_crc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dr_wr = 1'b0;
    logic [1:0] dr_size = 2'b00;
    logic       dr_rd = 1'b0;
    logic       init_wr = 1'b0;
    logic       poly_wr = 1'b0;
    logic       cr_reset = 1'b0;
    logic [1:0] size_out;
    logic       bus_wait, busy, buffer_en, byte_en, bypass_byte0, bypass_size;
    logic [1:0] byte_sel;
    logic       crc_out_en, set_crc_init_sel, clear_crc_init_sel, buffer_rst;
    logic       crc_init_en, crc_poly_en;

    int checks = 0;
    int errors = 0;

    crc_control dut (
        .clk(clk), .rst(rst), .dr_wr(dr_wr), .dr_size(dr_size), .dr_rd(dr_rd),
        .init_wr(init_wr), .poly_wr(poly_wr), .cr_reset(cr_reset), .size_out(size_out),
        .bus_wait(bus_wait), .busy(busy), .buffer_en(buffer_en), .byte_en(byte_en),
        .byte_sel(byte_sel), .bypass_byte0(bypass_byte0), .bypass_size(bypass_size),
        .crc_out_en(crc_out_en), .set_crc_init_sel(set_crc_init_sel),
        .clear_crc_init_sel(clear_crc_init_sel), .buffer_rst(buffer_rst),
        .crc_init_en(crc_init_en), .crc_poly_en(crc_poly_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Minimal datapath: the buffer size register and the latched operation size
    logic [1:0] bf_size, size_ff;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bf_size <= 2'b10;
            size_ff <= 2'b10;
        end else begin
            if (buffer_rst) bf_size <= 2'b10;
            else if (buffer_en) bf_size <= dr_size;
            if (byte_en) size_ff <= bf_size;
        end
    end
    assign size_out = bypass_size ? bf_size : size_ff;

    // Reference: one pending buffered write plus the write currently being stepped byte by byte
    bit         m_active, m_pend_v, m_last_acc;
    int         m_idx, m_n;
    logic [1:0] m_pend_size;
    bit         u_b0, u_acc, u_np;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_pend_v = 0; m_idx = 0; m_n = 0; m_last_acc = 0;
        end else begin
            u_b0  = m_active && m_idx == 0;
            u_acc = dr_wr && !cr_reset && (!m_pend_v || u_b0);
            m_last_acc = u_acc;
            if (cr_reset) begin
                m_active = 0;
                m_pend_v = 0;
            end else begin
                u_np = u_acc || (m_pend_v && !u_b0);
                if (u_acc) m_pend_size = dr_size;
                m_pend_v = u_np;
                if (m_active && m_idx + 1 < m_n) m_idx++;
                else if (u_np) begin
                    m_active = 1; m_idx = 0; m_n = nbytes(m_pend_size);
                end else m_active = 0;
            end
        end
    end

    bit e_b0, e_acc, e_busy, e_init;
    always @(negedge clk) begin
        if (!rst) begin
            e_b0   = m_active && m_idx == 0;
            e_acc  = dr_wr && !cr_reset && (!m_pend_v || e_b0);
            e_busy = m_active || m_pend_v;
            e_init = init_wr && !e_busy && !cr_reset;
            chk("busy", busy, e_busy);
            chk("buffer_en", buffer_en, e_acc);
            chk("byte_en", byte_en, e_b0);
            chk("byte_sel", byte_sel, m_active ? m_idx : 0);
            chk("bypass_byte0", bypass_byte0, e_b0);
            chk("bypass_size", bypass_size, e_b0);
            chk("set_crc_init_sel", set_crc_init_sel, e_b0);
            chk("crc_out_en", crc_out_en, m_active);
            chk("buffer_rst", buffer_rst, cr_reset);
            chk("crc_init_en", crc_init_en, e_init);
            chk("clear_crc_init_sel", clear_crc_init_sel, cr_reset || e_init);
            chk("crc_poly_en", crc_poly_en, poly_wr && !e_busy);
            chk("bus_wait", bus_wait, (dr_wr && !e_acc) || ((init_wr || poly_wr || dr_rd) && e_busy)
                                      || (init_wr && cr_reset));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_bus_wait", bus_wait, 0);
        chk("rst_byte_sel", byte_sel, 0);
        chk("rst_crc_out_en", crc_out_en, 0);
        tick(); rst = 1'b0;
        tick();

        // Word write from idle: bytes 0..3 on the next four cycles, idle on the fifth
        dr_wr = 1; dr_size = 2'b10;
        @(negedge clk); chk("w_accept", buffer_en, 1); chk("w_wait", bus_wait, 0);
        tick(); dr_wr = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w_byte_sel", byte_sel, k);
            chk("w_out_en", crc_out_en, 1);
            chk("w_bypass", bypass_byte0, (k == 0));
            tick();
        end
        @(negedge clk); chk("w_busy_fall", busy, 0);
        tick();

        // Byte then halfword: halfword accepted during the byte's BYTE0
        dr_wr = 1; dr_size = 2'b00;
        tick(); dr_size = 2'b01;
        @(negedge clk); chk("bh_b0", byte_en, 1); chk("bh_nowait", bus_wait, 0);
        tick(); dr_wr = 0;
        @(negedge clk); chk("bh_b0_half", byte_en, 1);
        tick();
        @(negedge clk); chk("bh_b1", byte_sel, 1);
        tick();
        @(negedge clk); chk("bh_idle", busy, 0);
        tick();

        // Poly write and result read stall for the whole word calculation
        dr_wr = 1; dr_size = 2'b10;
        tick(); dr_wr = 0; poly_wr = 1; dr_rd = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("p_wait", bus_wait, 1); chk("p_en_low", crc_poly_en, 0);
            tick();
        end
        @(negedge clk); chk("p_en", crc_poly_en, 1); chk("p_nowait", bus_wait, 0);
        tick(); poly_wr = 0; dr_rd = 0;
        @(negedge clk); chk("p_en_once", crc_poly_en, 0);
        tick();

        // cr_reset in BYTE2 with a write pending: abort, then accept one cycle later
        dr_wr = 1; dr_size = 2'b10;
        tick(); dr_wr = 0;
        tick(); tick();
        dr_wr = 1; cr_reset = 1;
        @(negedge clk);
        chk("cr_rst", buffer_rst, 1); chk("cr_clr", clear_crc_init_sel, 1); chk("cr_wait", bus_wait, 1);
        tick(); cr_reset = 0;
        @(negedge clk); chk("cr_idle", busy, 0); chk("cr_acc", buffer_en, 1);
        tick(); dr_wr = 0;
        @(negedge clk); chk("cr_chain", set_crc_init_sel, 1);
        for (int k = 0; k < 5; k++) tick();

        // Asynchronous reset in the middle of BYTE1
        dr_wr = 1; dr_size = 2'b10;
        tick(); dr_wr = 0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_byte_sel", byte_sel, 0);
        chk("ar_out_en", crc_out_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_wait", bus_wait, 0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("ar_idle", busy, 0);
        tick();

        // Randomized traffic; data writes are held while stalled
        for (int c = 0; c < 4000; c++) begin
            if (!(dr_wr && !m_last_acc)) begin
                dr_wr   = ($urandom_range(0, 2) == 0);
                dr_size = 2'($urandom_range(0, 3));
            end
            init_wr  = ($urandom_range(0, 15) == 0);
            poly_wr  = ($urandom_range(0, 15) == 0);
            dr_rd    = ($urandom_range(0, 11) == 0);
            cr_reset = ($urandom_range(0, 39) == 0);
            tick();
        end
        dr_wr = 0; init_wr = 0; poly_wr = 0; dr_rd = 0; cr_reset = 0;
        for (int k = 0; k < 6; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
